// File: rtl/combo_code_sender.sv
// Sends a stored code as {A,B} digit pairs with ack handshake, timed gaps and ack timeout.
// Latency: valid rises 1 clock after start and falls 1 clock after ack; the gap between pairs is GAP_CYCLES clocks.
// Backpressure: each pair is held until ack arrives, up to TIMEOUT_CYCLES clocks.
module combo_code_sender #(
  parameter int NUM_STEPS      = 3,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       ack,
  input  logic       load,
  input  logic [1:0] load_idx,
  input  logic [7:0] code_in,
  output logic [3:0] A_out,
  output logic [3:0] B_out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [6:0] H1,
  output logic [6:0] H2,
  output logic [6:0] H3
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP, S_DONE} state_t;

  localparam logic [1:0]  LAST_STEP = 2'(NUM_STEPS - 1);
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_step;
  logic [7:0]  r_gap_cnt;
  logic [15:0] r_to_cnt;
  logic [7:0]  r_code [0:3];
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [1:0]  w_next_step;
  logic        w_load_ok;

  assign w_next_step = r_step + 2'd1;
  assign w_load_ok   = load && (int'(load_idx) < NUM_STEPS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_step    <= 2'd0;
      r_gap_cnt <= 8'd0;
      r_to_cnt  <= 16'd0;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_code[0] <= 8'h28;
      r_code[1] <= 8'h19;
      r_code[2] <= 8'h96;
      r_code[3] <= 8'h00;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        // error is deliberately kept so a timeout stays visible after abort
        r_state <= S_IDLE;
        r_step  <= 2'd0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_a     <= 4'd0;
        r_b     <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state  <= S_PRESENT;
              r_step   <= 2'd0;
              r_error  <= 1'b0;
              r_valid  <= 1'b1;
              r_busy   <= 1'b1;
              r_to_cnt <= 16'd0;
              r_a      <= r_code[0][7:4];
              r_b      <= r_code[0][3:0];
            end else if (w_load_ok) begin
              r_code[load_idx] <= code_in;
            end
          end
          S_PRESENT: begin
            if (ack) begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_LOAD;
              r_valid   <= 1'b0;
              r_a       <= 4'd0;
              r_b       <= 4'd0;
            end else if (r_to_cnt == TO_LAST) begin
              r_state <= S_IDLE;
              r_error <= 1'b1;
              r_step  <= 2'd0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_a     <= 4'd0;
              r_b     <= 4'd0;
            end else begin
              r_to_cnt <= r_to_cnt + 16'd1;
            end
          end
          S_GAP: begin
            if (r_gap_cnt == 8'd1) begin
              if (r_step == LAST_STEP) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state  <= S_PRESENT;
                r_step   <= w_next_step;
                r_valid  <= 1'b1;
                r_to_cnt <= 16'd0;
                r_a      <= r_code[w_next_step][7:4];
                r_b      <= r_code[w_next_step][3:0];
              end
            end else begin
              r_gap_cnt <= r_gap_cnt - 8'd1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_step  <= 2'd0;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'h0: f_seg = 7'h3F;
      4'h1: f_seg = 7'h06;
      4'h2: f_seg = 7'h5B;
      4'h3: f_seg = 7'h4F;
      4'h4: f_seg = 7'h66;
      4'h5: f_seg = 7'h6D;
      4'h6: f_seg = 7'h7D;
      4'h7: f_seg = 7'h07;
      4'h8: f_seg = 7'h7F;
      4'h9: f_seg = 7'h67;
      4'hA: f_seg = 7'h77;
      4'hB: f_seg = 7'h7C;
      4'hC: f_seg = 7'h39;
      4'hD: f_seg = 7'h5E;
      4'hE: f_seg = 7'h79;
      default: f_seg = 7'h71;
    endcase
  endfunction

  assign A_out = r_a;
  assign B_out = r_b;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;

  // Displays are active-low; all segments high means blank.
  assign H1 = r_valid ? ~f_seg(r_a) : 7'h7F;
  assign H2 = r_valid ? ~f_seg(r_b) : 7'h7F;
  assign H3 = r_busy  ? ~f_seg({2'b00, r_step}) : 7'h7F;

endmodule

// File: tb/tb_combo_code_sender.sv
// Directed bench for combo_code_sender with hand-computed expectations.
module tb_combo_code_sender;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ack = 1'b0;
  logic       load = 1'b0;
  logic [1:0] load_idx = 2'd0;
  logic [7:0] code_in = 8'h00;
  logic [3:0] A_out, B_out;
  logic       valid, busy, done, error;
  logic [6:0] H1, H2, H3;

  int n_vec = 0;
  int n_err = 0;

  combo_code_sender dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .ack(ack),
    .load(load), .load_idx(load_idx), .code_in(code_in),
    .A_out(A_out), .B_out(B_out), .valid(valid), .busy(busy), .done(done),
    .error(error), .H1(H1), .H2(H2), .H3(H3)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic ack_after2();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_n);
    int n = 0;
    while (valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 16'(n), 16'(exp_n));
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 16'(n), 16'(exp_n));
  endtask

  task automatic chk_pair(input string tag, input logic [3:0] a, input logic [3:0] b);
    chk({tag, "_a"}, 16'(A_out), 16'(a));
    chk({tag, "_b"}, 16'(B_out), 16'(b));
  endtask

  initial begin
    int n;
    int ndone;
    #1;
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_error", 16'(error), 16'd0);
    chk("rst_ab", {8'd0, A_out, B_out}, 16'h00);
    chk("rst_h1", 16'(H1), 16'h7F);
    chk("rst_h2", 16'(H2), 16'h7F);
    chk("rst_h3", 16'(H3), 16'h7F);
    tick();
    reset = 1'b0;

    // Default code run
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_valid", 16'(valid), 16'd1);
    chk("run_busy", 16'(busy), 16'd1);
    chk_pair("run_p0", 4'h2, 4'h8);
    chk("run_h1_p0", 16'(H1), 16'h24);
    chk("run_h2_p0", 16'(H2), 16'h00);
    chk("run_h3_p0", 16'(H3), 16'h40);
    ack_after2();
    chk("run_gap_valid", 16'(valid), 16'd0);
    chk("run_gap_h1", 16'(H1), 16'h7F);
    chk("run_gap_ab", {8'd0, A_out, B_out}, 16'h00);
    wait_valid("run_gap1_len", 4);
    chk_pair("run_p1", 4'h1, 4'h9);
    chk("run_h3_p1", 16'(H3), 16'h79);
    ack_after2();
    wait_valid("run_gap2_len", 4);
    chk_pair("run_p2", 4'h9, 4'h6);
    chk("run_h1_p2", 16'(H1), 16'h18);
    ack_after2();
    wait_done("run_done_lat", 4);
    tick();
    chk("run_done_1clk", 16'(done), 16'd0);
    chk("run_idle_busy", 16'(busy), 16'd0);
    chk("run_idle_h3", 16'(H3), 16'h7F);

    // ack outside PRESENT is ignored
    ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    chk("idle_ack_busy", 16'(busy), 16'd0);

    // Timeout
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("to_len", 16'(n), 16'd200);
    chk("to_error", 16'(error), 16'd1);
    chk("to_valid", 16'(valid), 16'd0);
    tick();
    chk("to_sticky", 16'(error), 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_clear", 16'(error), 16'd0);
    chk("to_restart_valid", 16'(valid), 16'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_present_busy", 16'(busy), 16'd0);

    // Abort during the second gap
    start = 1'b1;
    tick();
    start = 1'b0;
    ack_after2();
    wait_valid("ab_gap1_len", 4);
    ack_after2();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", 16'(valid), 16'd0);
    chk("ab_busy", 16'(busy), 16'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("ab_no_done", 16'(ndone), 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_pair("ab_restart", 4'h2, 4'h8);
    chk("ab_restart_h3", 16'(H3), 16'h40);

    // ack+abort in PRESENT -> IDLE, not GAP
    ack = 1'b1;
    abort = 1'b1;
    tick();
    ack = 1'b0;
    abort = 1'b0;
    chk("ackab_busy", 16'(busy), 16'd0);

    // start+load in IDLE: load dropped
    start = 1'b1;
    load = 1'b1;
    load_idx = 2'd0;
    code_in = 8'h44;
    tick();
    start = 1'b0;
    load = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_pair("stld_entry0", 4'h2, 4'h8);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Load in IDLE, then load attempted during PRESENT
    load = 1'b1;
    load_idx = 2'd1;
    code_in = 8'hA5;
    tick();
    load_idx = 2'd0;
    code_in = 8'h77;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_pair("ld_p0", 4'h7, 4'h7);
    ack_after2();
    wait_valid("ld_gap_len", 4);
    chk_pair("ld_p1", 4'hA, 4'h5);
    chk("ld_h2", 16'(H2), 16'h12);
    chk("ld_h1", 16'(H1), 16'h08);
    load = 1'b1;
    load_idx = 2'd1;
    code_in = 8'h33;
    tick();
    load = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ack_after2();
    wait_valid("ld2_gap_len", 4);
    chk_pair("ld_present_ignored", 4'hA, 4'h5);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Restore entry1 to 19, keep entry0 = 77, then reset mid-PRESENT
    load = 1'b1;
    load_idx = 2'd1;
    code_in = 8'h19;
    tick();
    load = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ack_after2();
    wait_valid("rm_gap_len", 4);
    chk_pair("rm_p1", 4'h1, 4'h9);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_valid", 16'(valid), 16'd0);
    chk("rm_busy", 16'(busy), 16'd0);
    chk("rm_ab", {8'd0, A_out, B_out}, 16'h00);
    chk("rm_h1", 16'(H1), 16'h7F);
    chk("rm_h3", 16'(H3), 16'h7F);
    chk("rm_done", 16'(done), 16'd0);
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rm_first_edge_valid", 16'(valid), 16'd1);
    chk_pair("rm_p0_restored", 4'h2, 4'h8);
    ack_after2();
    wait_valid("rm_run_gap1", 4);
    chk_pair("rm_p1_restored", 4'h1, 4'h9);
    ack_after2();
    wait_valid("rm_run_gap2", 4);
    chk_pair("rm_p2_restored", 4'h9, 4'h6);
    ack_after2();
    wait_done("rm_run_done", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
